// File: rtl/bk_multiword_add_seq.sv
// Multi-precision add/subtract sequencer feeding a 16-bit Brent-Kung adder.
// Operands are walked LS word first; adder Cout is chained back into Cin.
module bk_multiword_add_seq #(
    parameter int NUM_WORDS = 4,
    parameter int WORD_W    = 16,
    localparam int W        = WORD_W * NUM_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_a,
    input  logic [W-1:0]      in_b,
    input  logic              in_sub,
    output logic [WORD_W-1:0] add_a,
    output logic [WORD_W-1:0] add_b,
    output logic              add_cin,
    input  logic [WORD_W-1:0] add_sum,
    input  logic              add_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_sum,
    output logic              out_cout,
    output logic              out_ovf
);

    localparam int IDX_W = $clog2(NUM_WORDS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             sub_q, sub_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WORD_W-1:0] a_word;
    logic [WORD_W-1:0] b_word;
    logic              last_word;

    assign a_word    = a_q[WORD_W*idx_q +: WORD_W];
    assign b_word    = b_q[WORD_W*idx_q +: WORD_W];
    assign last_word = (idx_q == IDX_W'(NUM_WORDS - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    sub_d   = in_sub;
                    idx_d   = '0;
                    // subtract is A + ~B + 1: the +1 enters as initial carry
                    carry_d = in_sub;
                    state_d = RUN;
                end
            end
            RUN: begin
                add_a   = a_word;
                add_b   = b_word ^ {WORD_W{sub_q}};
                add_cin = carry_q;
                sum_d[WORD_W*idx_q +: WORD_W] = add_sum;
                carry_d = add_cout;
                idx_d   = idx_q + 1'b1;
                if (last_word) begin
                    cout_d  = add_cout;
                    ovf_d   = (a_word[WORD_W-1] == add_b[WORD_W-1]) &&
                              (add_sum[WORD_W-1] != a_word[WORD_W-1]);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_bk_multiword_add_seq.sv
// Scoreboard bench for bk_multiword_add_seq with a behavioural adder model.
// Expected results come from whole-operand arithmetic, not word slicing.
module tb_bk_multiword_add_seq;

    localparam int NW = 4;
    localparam int W  = 16 * NW;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_sub = 1'b0;
    logic [15:0]  add_a;
    logic [15:0]  add_b;
    logic         add_cin;
    logic [15:0]  add_sum;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc = -1;
    int acc_cyc = -1;
    bit rnd_rdy = 1'b0;
    exp_t q[$];
    logic [NW-1:0] cin_seen;
    logic [15:0]   b_seen[NW];

    bk_multiword_add_seq #(.NUM_WORDS(NW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    // Stand-in for the combinational 16-bit adder
    logic [16:0] add_res;
    assign add_res  = {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);
    assign add_sum  = add_res[15:0];
    assign add_cout = add_res[16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic s);
        exp_t e;
        logic [W:0] wide;
        if (s) begin
            wide  = {1'b0, a} - {1'b0, b};
            e.sum  = wide[W-1:0];
            e.cout = (a >= b);
            e.ovf  = (a[W-1] != b[W-1]) && (e.sum[W-1] != a[W-1]);
        end else begin
            wide  = {1'b0, a} + {1'b0, b};
            e.sum  = wide[W-1:0];
            e.cout = wide[W];
            e.ovf  = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
        end
        return e;
    endfunction

    task automatic chk(string name, logic [W-1:0] got, logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            hs_cyc = cyc;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got sum %h, expected none", out_sum);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_sum", out_sum, e.sum);
                chk("out_cout", W'(out_cout), W'(e.cout));
                chk("out_ovf", W'(out_ovf), W'(e.ovf));
            end
        end
    end

    // Call away from a rising edge; returns at the first DONE negedge when lat=1
    task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic s,
                         bit keep, bit lat);
        bit quiet;
        in_a = a;
        in_b = b;
        in_sub = s;
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
            in_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        @(posedge clk);
        q.push_back(model(a, b, s));
        #1;
        if (!keep) in_valid = 1'b0;
        if (!lat) return;
        quiet = 1'b1;
        for (int i = 0; i < NW; i++) begin
            @(negedge clk);
            cin_seen[i] = add_cin;
            b_seen[i] = add_b;
            if (out_valid) quiet = 1'b0;
        end
        @(negedge clk);
        chk("latency_early", W'(quiet), W'(1));
        chk("latency_valid", W'(out_valid), W'(1));
    endtask

    task automatic check_idle_outputs(string tag);
        chk({tag, "_in_ready"}, W'(in_ready), W'(1));
        chk({tag, "_out_valid"}, W'(out_valid), W'(0));
        chk({tag, "_add"}, W'({add_a, add_b, add_cin}), W'(0));
        chk({tag, "_out_sum"}, out_sum, '0);
        chk({tag, "_flags"}, W'({out_cout, out_ovf}), W'(0));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // carry ripples through every word
        issue({W{1'b1}}, 64'd1, 1'b0, 1'b0, 1'b1);
        chk("ripple_cin", W'(cin_seen), W'(4'b1110));
        chk("ripple_sum", out_sum, '0);
        @(negedge clk);

        // borrow: first word sees inverted B with Cin=1
        issue('0, 64'd1, 1'b1, 1'b0, 1'b1);
        chk("sub_b0", W'(b_seen[0]), W'(16'hFFFE));
        chk("sub_cin0", W'(cin_seen[0]), W'(1));
        chk("sub_sum", out_sum, {W{1'b1}});
        @(negedge clk);

        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1);
        chk("ovf_add", W'({out_ovf, out_cout}), W'(2'b10));
        @(negedge clk);
        issue(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 1'b1);
        chk("ovf_sub", W'({out_ovf, out_cout}), W'(2'b11));
        @(negedge clk);

        // backpressure with an ignored request in the hold window
        out_ready = 1'b0;
        issue(64'd3, 64'd4, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", W'(out_valid), W'(1));
            chk("hold_in_ready", W'(in_ready), W'(0));
            chk("hold_sum", out_sum, 64'd7);
            chk("hold_cout", W'(out_cout), W'(0));
            @(posedge clk);
            #1;
            in_valid = (k == 1);
            in_a = 64'd100;
            in_b = 64'd200;
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_hold_idle", W'({in_ready, out_valid}), W'(2'b10));
        end

        // reset while idx == 2
        issue(64'h1234, 64'h5678, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(64'd1, 64'd2, 1'b0, 1'b0, 1'b1);
        chk("fresh_sum", out_sum, 64'd3);
        @(negedge clk);

        // back-to-back with in_valid held
        issue(64'd5, 64'd7, 1'b0, 1'b1, 1'b1);
        issue(64'd10, 64'd3, 1'b1, 1'b1, 1'b1);
        in_valid = 1'b0;
        chk("b2b_gap", W'(acc_cyc - hs_cyc), W'(1));
        chk("b2b_sum", out_sum, 64'd7);
        @(negedge clk);

        // random traffic with random backpressure
        rnd_rdy = 1'b1;
        for (int t = 0; t < 40; t++) begin
            logic [W-1:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (t % 5 == 0) rb = ra;
            if (t % 7 == 0) rb[W-1] = ~ra[W-1];
            issue(ra, rb, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        end
        rnd_rdy = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int n = 0; n < 200 && q.size() != 0; n++) @(negedge clk);
        chk("drain", W'(q.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/bk_multiword_add_seq.md
Name: bk_multiword_add_seq

Overview:
- Multi-precision add/subtract sequencer that sits directly upstream of the team's 16-bit Brent-Kung adder and drives its a/b/Cin inputs.
- Accepts wide operands through a valid/ready handshake and slices them into 16-bit words, least-significant word first, one word per clock.
- Chains the adder's Cout back into Cin and collects the 16-bit sums into a wide result with carry-out and signed overflow.

Parameters:
- NUM_WORDS, 4, number of 16-bit words per operand (≥2); operand width W = 16*NUM_WORDS.
- WORD_W, 16, word width fixed by the adder; must not be overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  sequencer can accept an operand.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_sub  input  1  0 = A+B, 1 = A−B.
- add_a  output  16  word to the adder's a input.
- add_b  output  16  word to the adder's b input (already inverted for subtract).
- add_cin  output  1  to the adder's Cin.
- add_sum  input  16  adder sum (combinational, same cycle).
- add_cout  input  1  adder Cout.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  W  result.
- out_cout  output  1  final carry; for subtract, 1 = no borrow.
- out_ovf  output  1  two's-complement overflow.

Behaviour:
- Reset (async, on rst_n low): state=IDLE, word index=0, carry reg=0, all operand/result regs=0. Outputs: in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, add_a/add_b/add_cin=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready → capture in_a, in_b, in_sub; idx=0; carry=in_sub; go to RUN.
  - RUN: in_ready=0.
    - add_a = A[16*idx +: 16].
    - add_b = B[16*idx +: 16], XORed with {16{sub}}.
    - add_cin = carry.
    - Each edge: result word idx ← add_sum; carry ← add_cout; idx++.
    - When idx==NUM_WORDS−1, the same edge also latches out_cout=add_cout and out_ovf=(a_msb==b_eff_msb)&&(add_sum[15]!=a_msb); go to DONE.
  - DONE: out_valid=1, in_ready=0. out_sum/out_cout/out_ovf held stable. On out_ready → out_valid=0, go to IDLE.
- Latency: accept edge E; out_valid rises after edge E+NUM_WORDS. Throughput: one operation per NUM_WORDS+2 cycles minimum, since IDLE lasts at least one cycle after the DONE handshake.
- add_a/add_b/add_cin are 0 outside RUN. The adder is purely combinational; no extra wait cycle.
- in_valid while busy is ignored; operands are not captured.
- out_ready low in DONE holds indefinitely with no change; out_ready high outside DONE has no effect.
- in_a/in_b changing after capture has no effect on the in-flight operation.
- Reset mid-RUN or mid-DONE aborts the operation immediately; the result is discarded and outputs return to reset values.
- Arithmetic is modulo 2^W. A wrap produces out_cout=1 (add) or out_cout=0 (subtract with borrow).

Test Plan:
- Add carry ripple (NUM_WORDS=4): A=FFFF_FFFF_FFFF_FFFF, B=1, sub=0 → out_sum=0, out_cout=1, out_ovf=0; out_valid 4 cycles after accept; add_cin per cycle = 0,1,1,1.
- Subtract borrow: A=0, B=1, sub=1 → out_sum=FFFF_FFFF_FFFF_FFFF, out_cout=0, out_ovf=0; first-cycle add_b=FFFE, add_cin=1.
- Signed overflow: A=7FFF_FFFF_FFFF_FFFF, B=1, add → out_sum=8000_0000_0000_0000, out_ovf=1, out_cout=0. A=8000_0000_0000_0000, B=1, sub → out_sum=7FFF_FFFF_FFFF_FFFF, out_ovf=1, out_cout=1.
- Backpressure: out_ready low for 5 cycles in DONE → out_valid, out_sum, out_cout held and in_ready=0 throughout; in_valid pulsed during this window is not captured.
- Reset mid-RUN: assert rst_n=0 at idx=2 → in_ready=1, out_valid=0, add_* =0 immediately; a fresh 1+2 completes with sum 3.
- Back-to-back: in_valid held high with two requests (5+7 then 10−3) and out_ready=1 → results 12 then 7, each with out_valid high for exactly one cycle, second accepted on the cycle after the first handshake returns to IDLE.
